// File: rtl/fabric_config_loader_pkg.sv
// Shared definitions for the fabric config loader and the config-chain model.
package fabric_config_loader_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] ST_SHIFT = 3'd2;
    localparam logic [STATE_W-1:0] ST_LATCH = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    // Number of incoming words needed to fill a chain; the last word may be partial.
    function automatic int words_per_chain(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Parallel-load, serial-out right shifter feeding the config chain LSB-first.
module cfg_shift_reg #(
    parameter int WORD_W = 8
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Load,
    input  logic              i_Shift,
    input  logic [WORD_W-1:0] i_Data,
    output logic              o_Serial
);

    logic [WORD_W-1:0] shreg;

    // Capture a whole word, or move it one bit toward the serial output.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            shreg <= '0;
        end else if (i_Load) begin
            shreg <= i_Data;
        end else if (i_Shift) begin
            shreg <= shreg >> 1;
        end
    end

    assign o_Serial = shreg[0];

endmodule

// File: rtl/fabric_config_loader.sv
// Loads a fabric tile's serial config chain from a word stream, latches it,
// then releases the user-logic clock-enable.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for the first start request after reset
//   LOAD  | ready for the next config word
//   SHIFT | streaming the captured word into the chain, one bit a cycle
//   LATCH | one-cycle strobe moving the chain into the active config
//   DONE  | chain active, user design enabled; start reloads
module fabric_config_loader
    import fabric_config_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Start,
    input  logic              i_WordValid,
    output logic              o_WordReady,
    input  logic [WORD_W-1:0] i_Word,
    output logic              o_CfgData,
    output logic              o_CfgShiftEn,
    output logic              o_CfgLatch,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_UserEnable
);

    localparam int BC_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0] WB_LAST = WB_W'(WORD_W - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [BC_W-1:0]    bit_cnt;
    logic [WB_W-1:0]    word_bit;
    logic               start_ok;
    logic               word_accept;
    logic               shift_lsb;

    assign start_ok    = i_Start && ((state == ST_IDLE) || (state == ST_DONE));
    assign word_accept = (state == ST_LOAD) && i_WordValid;

    // Next-state decode; chain-full wins over word-exhausted so a partial
    // final word never shifts beyond the chain length.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_Start) state_nxt = ST_LOAD;
            ST_LOAD:  if (i_WordValid) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (bit_cnt == BC_LAST) begin
                    state_nxt = ST_LATCH;
                end else if (word_bit == WB_LAST) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LATCH: state_nxt = ST_DONE;
            ST_DONE:  if (i_Start) state_nxt = ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any load before the latch strobe.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Chain-position and in-word bit counters.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            bit_cnt  <= '0;
            word_bit <= '0;
        end else if (start_ok) begin
            bit_cnt  <= '0;
            word_bit <= '0;
        end else if (word_accept) begin
            word_bit <= '0;
        end else if (state == ST_SHIFT) begin
            bit_cnt  <= bit_cnt + BC_W'(1);
            word_bit <= word_bit + WB_W'(1);
        end
    end

    cfg_shift_reg #(
        .WORD_W (WORD_W)
    ) u_shift (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Load    (word_accept),
        .i_Shift   (state == ST_SHIFT),
        .i_Data    (i_Word),
        .o_Serial  (shift_lsb)
    );

    assign o_WordReady  = (state == ST_LOAD);
    assign o_CfgShiftEn = (state == ST_SHIFT);
    assign o_CfgData    = (state == ST_SHIFT) && shift_lsb;
    assign o_CfgLatch   = (state == ST_LATCH);
    assign o_Busy       = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_LATCH);
    assign o_Done       = (state == ST_DONE);
    assign o_UserEnable = (state == ST_DONE);

endmodule

// File: tb/tb_fabric_config_loader.sv
// Scoreboard bench: the driver queues the expected serial bit stream for each
// word it hands over; a negedge monitor pops and compares on every shift.
module tb_fabric_config_loader;

    localparam int CL = 12;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, valid;
    logic [WW-1:0] word;
    logic          ready, cdata, shen, latch, busy, done, uen;

    logic          e_start, e_valid;
    logic [WW-1:0] e_word;
    logic          r8, d8, s8, l8, b8, dn8, u8;
    logic          r1, d1, s1, l1, b1, dn1, u1;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];
    bit exp_bit;
    int shift_cnt   = 0;
    int latch_cnt   = 0;
    int bits_pushed = 0;
    bit prev_latch  = 0;

    always #5 clk = ~clk;

    fabric_config_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start), .i_WordValid(valid),
        .o_WordReady(ready), .i_Word(word), .o_CfgData(cdata), .o_CfgShiftEn(shen),
        .o_CfgLatch(latch), .o_Busy(busy), .o_Done(done), .o_UserEnable(uen));

    fabric_config_loader #(.CHAIN_LEN(8), .WORD_W(WW)) u_dut8 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(e_start), .i_WordValid(e_valid),
        .o_WordReady(r8), .i_Word(e_word), .o_CfgData(d8), .o_CfgShiftEn(s8),
        .o_CfgLatch(l8), .o_Busy(b8), .o_Done(dn8), .o_UserEnable(u8));

    fabric_config_loader #(.CHAIN_LEN(1), .WORD_W(WW)) u_dut1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(e_start), .i_WordValid(e_valid),
        .o_WordReady(r1), .i_Word(e_word), .o_CfgData(d1), .o_CfgShiftEn(s1),
        .o_CfgLatch(l1), .o_Busy(b1), .o_Done(dn1), .o_UserEnable(u1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] main_outs();
        return {ready, cdata, shen, latch, busy, done, uen};
    endfunction

    // Monitor: compare serial data on every shift, latch bookkeeping, done timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_latch) check("after_latch_lat_done_uen", {latch, done, uen}, 3'b011);
            prev_latch = latch;
            if (shen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_shift: shift with empty expected queue, data %0b", cdata);
                end else begin
                    exp_bit = exp_q.pop_front();
                    check("cfg_data", cdata, exp_bit);
                end
                shift_cnt++;
            end
            if (latch) begin
                check("latch_shift_count", shift_cnt, CL);
                check("latch_queue_left", exp_q.size(), 0);
                latch_cnt++;
            end
        end else begin
            prev_latch = 0;
        end
    end

    task automatic start_load();
        shift_cnt   = 0;
        bits_pushed = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        int t = 0;
        @(negedge clk);
        valid = 1'b1;
        word  = w;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL word_ready_timeout: ready %0b required 1", ready);
            valid = 1'b0;
            return;
        end
        for (int i = 0; i < WW; i++) begin
            if (bits_pushed < CL) begin
                exp_q.push_back(w[i]);
                bits_pushed++;
            end
        end
        @(negedge clk);
        valid = 1'b0;
        word  = WW'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done", done, 1'b1);
        check("user_enable", uen, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("shifts_per_load", shift_cnt, CL);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("ready_reached", ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] w1, w2, ew;
        int lat_before, t;
        int acc8, acc1, sh8, sh1, lc8, lc1;

        rst_n = 1'b0; start = 1'b0; valid = 1'b0; word = '0;
        e_start = 1'b0; e_valid = 1'b0; e_word = '0;

        // Reset held: toggling inputs must not move any output.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom); valid = 1'($urandom); word = WW'($urandom);
            #2 check("reset_outputs", main_outs(), 7'b0);
        end
        @(negedge clk);
        start = 1'b0; valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outputs", main_outs(), 7'b0);
        end

        // Full load with the reference words.
        start_load();
        check("ready_after_start", ready, 1'b1);
        check("busy_after_start", busy, 1'b1);
        send_word(8'hA5);
        send_word(8'h3C);
        wait_done();
        check("latch_count_load1", latch_cnt, 1);

        // Valid stalled in LOAD: no shifting, no word lost.
        w1 = WW'($urandom); w2 = WW'($urandom);
        start_load();
        send_word(w1);
        wait_ready();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_shift_en", shen, 1'b0);
            check("stall_ready", ready, 1'b1);
        end
        send_word(w2);
        wait_done();
        check("latch_count_load2", latch_cnt, 2);

        // Abort mid-shift with reset, then a fresh load.
        start_load();
        send_word(WW'($urandom));
        t = 0;
        while (shift_cnt < 6 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("abort_reached_6_bits", shift_cnt >= 6, 1'b1);
        lat_before = latch_cnt;
        #2 rst_n = 1'b0;
        #1 check("abort_async_outputs", main_outs(), 7'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_held_outputs", main_outs(), 7'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_latch", latch_cnt, lat_before);
        start_load();
        send_word(WW'($urandom));
        send_word(WW'($urandom));
        wait_done();
        check("latch_count_after_abort", latch_cnt, lat_before + 1);

        // Start during SHIFT is ignored; start in DONE reconfigures.
        start_load();
        send_word(WW'($urandom));
        t = 0;
        while (!shen && t < 50) begin
            @(negedge clk);
            t++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_shift_busy", busy, 1'b1);
        send_word(WW'($urandom));
        wait_done();
        lat_before = latch_cnt;
        start_load();
        check("reconf_done_dropped", done, 1'b0);
        check("reconf_uen_dropped", uen, 1'b0);
        check("reconf_ready", ready, 1'b1);
        send_word(WW'($urandom));
        send_word(WW'($urandom));
        wait_done();
        check("latch_count_reconf", latch_cnt, lat_before + 1);

        // Edge chain lengths: one word consumed, chain-length shifts each.
        ew = WW'($urandom);
        acc8 = 0; acc1 = 0; sh8 = 0; sh1 = 0; lc8 = 0; lc1 = 0;
        @(negedge clk);
        e_start = 1'b1; e_valid = 1'b1; e_word = ew;
        @(negedge clk);
        e_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (r8 && e_valid) acc8++;
            if (r1 && e_valid) acc1++;
            if (s8) begin
                check("edge8_data", d8, ew[sh8 % WW]);
                sh8++;
            end
            if (s1) begin
                check("edge1_data", d1, ew[sh1 % WW]);
                sh1++;
            end
            if (l8) lc8++;
            if (l1) lc1++;
            @(negedge clk);
        end
        e_valid = 1'b0;
        check("edge8_words", acc8, 1);
        check("edge1_words", acc1, 1);
        check("edge8_shifts", sh8, 8);
        check("edge1_shifts", sh1, 1);
        check("edge8_latches", lc8, 1);
        check("edge1_latches", lc1, 1);
        check("edge8_done", {dn8, u8}, 2'b11);
        check("edge1_done", {dn1, u1}, 2'b11);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
